// File: rtl/frame_packer.sv
// Word-to-frame packer: collects NWORDS words into a parallel frame held until acked.
// Optional shadow fill buffer (no-gap streaming) enabled by FRAME_PACKER_DBUF_EN.
module frame_packer #(
    parameter int  W      = 32,
    parameter int  NWORDS = 4,
    localparam int FW     = $clog2(NWORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic [W-1:0]  frame_o [NWORDS-1:0],
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic [FW-1:0] fill_level,
    output logic [7:0]    frame_count
);

    // state  | meaning
    // S_FILL | no frame presented; words fill frame_o directly
    // S_FULL | frame_o presented and held until frame_ack
    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t        r_state;
    logic [FW-1:0] r_fill;
    logic          r_valid;
    logic [7:0]    r_count;
    logic [W-1:0]  r_frame [NWORDS-1:0];

    logic          w_accept;
    logic          w_last;
    logic [FW-1:0] w_wr_idx;

    // First word received lands in the highest index.
    assign w_wr_idx    = FW'(NWORDS - 1) - r_fill;
    assign w_last      = (r_fill == FW'(NWORDS - 1));
    assign w_accept    = in_valid && in_ready;

    assign frame_o     = r_frame;
    assign frame_valid = r_valid;
    assign fill_level  = r_fill;
    assign frame_count = r_count;

`ifdef FRAME_PACKER_DBUF_EN
    logic [W-1:0] r_shadow    [NWORDS-1:0];
    logic [W-1:0] w_shadow_nx [NWORDS-1:0];
    logic         w_shadow_full;

    // In S_FULL r_fill counts the shadow buffer; stall only when both are full.
    assign in_ready      = !(r_state == S_FULL && r_fill == FW'(NWORDS));
    assign w_shadow_full = (r_fill == FW'(NWORDS)) || (w_accept && w_last);

    always_comb begin
        for (int i = 0; i < NWORDS; i++) begin
            w_shadow_nx[i] = r_shadow[i];
            if (r_state == S_FULL && w_accept && w_wr_idx == FW'(i))
                w_shadow_nx[i] = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FILL;
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                r_frame[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else if (flush) begin
            r_state <= S_FILL;
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept && w_last)
                r_count <= r_count + 8'd1;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < NWORDS; i++)
                            if (w_wr_idx == FW'(i)) r_frame[i] <= in_data;
                        r_fill <= r_fill + 1'b1;
                        if (w_last) begin
                            r_state <= S_FULL;
                            r_valid <= 1'b1;
                            r_fill  <= '0;
                        end
                    end
                end
                S_FULL: begin
                    r_shadow <= w_shadow_nx;
                    if (w_accept)
                        r_fill <= r_fill + 1'b1;
                    // A partial shadow moves down too and keeps filling in S_FILL.
                    if (frame_ack) begin
                        r_frame <= w_shadow_nx;
                        if (w_shadow_full) begin
                            r_fill <= '0;
                        end else begin
                            r_state <= S_FILL;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
`else
    assign in_ready = (r_state == S_FILL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FILL;
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            for (int i = 0; i < NWORDS; i++)
                r_frame[i] <= '0;
        end else if (flush) begin
            r_state <= S_FILL;
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < NWORDS; i++)
                            if (w_wr_idx == FW'(i)) r_frame[i] <= in_data;
                        r_fill <= r_fill + 1'b1;
                        if (w_last) begin
                            r_state <= S_FULL;
                            r_valid <= 1'b1;
                            r_count <= r_count + 8'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (frame_ack) begin
                        r_state <= S_FILL;
                        r_fill  <= '0;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
`endif

endmodule

// File: doc/frame_packer.md
Name: frame_packer

Overview:
- Upstream feeder for the 4-state output sequencer FSM.
- Accepts a stream of words over a valid/ready handshake and assembles NWORDS words into a frame.
- Presents the frame as a parallel array with frame_valid, and holds it until the consumer acknowledges.
- Arrival order maps to descending index: the first word received lands in frame_o[NWORDS-1], which is the word the sequencer emits first.

Parameters:
- W, 32, word width in bits; default matches int.
- NWORDS, 4, words per frame; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the frame being assembled (and presented).
- in_valid  input  1  in_data holds a valid word.
- in_data  input  W  input word; treated as signed int.
- in_ready  output  1  block can accept a word this cycle.
- frame_o  output  NWORDS x W  assembled frame, unpacked array [NWORDS-1:0].
- frame_valid  output  1  frame_o holds a complete frame.
- frame_ack  input  1  consumer has taken frame_o; sampled only while frame_valid=1.
- fill_level  output  $clog2(NWORDS+1)  words held in the filling buffer.
- frame_count  output  8  completed frames, wraps modulo 256.

Behaviour:
- Reset (reset=0, async): state FILL, fill_level=0, all frame_o words=0, frame_valid=0, frame_count=0, in_ready=1.
- States: FILL and FULL.
  - in_ready = (state==FILL), driven combinationally from state.
- Accept: in_valid && in_ready at a posedge.
  - The word is stored in frame_o[NWORDS-1-fill_level].
  - fill_level increments.
  - Other words are unchanged.
- Completion: the accept that makes fill_level reach NWORDS moves the block to FULL.
  - Next cycle: frame_valid=1, in_ready=0, frame_count+1, fill_level shows NWORDS.
  - Latency from the last accepted word to frame_valid is 1 cycle.
- FULL:
  - frame_o is stable.
  - in_valid is ignored, with no data loss, because in_ready=0.
  - frame_ack=1 at a posedge moves the block to FILL with fill_level=0.
  - Next cycle: frame_valid=0, in_ready=1.
  - frame_o words keep their old values until overwritten.
- frame_ack while frame_valid=0 has no effect.
- A frame_ack held high for multiple cycles releases exactly one frame.
- flush=1 has highest priority over accept and ack.
  - Next state is FILL with fill_level=0 and frame_valid=0.
  - A word offered in the same cycle is not stored; in_ready still reflects the current state, so upstream must drop or retry it.
  - frame_count is not incremented for a flushed partial frame.
  - If flush hits a completed frame that has not been acked, that frame is discarded and frame_count keeps the value it already incremented to.
- frame_count wraps 255 -> 0.
- Reset asserted mid-frame discards all partial contents immediately.

Optional Feature:
- Macro: FRAME_PACKER_DBUF_EN.
- Defined: adds a shadow fill buffer alongside the output buffer.
  - While frame_valid=1, incoming words fill the shadow buffer and in_ready stays 1.
  - fill_level reports the shadow buffer's count.
  - in_ready=0 only when both buffers are full.
  - On frame_ack with a full shadow (including a shadow that completes in the same cycle), the shadow contents move to frame_o on that edge and frame_valid stays 1 with no gap.
  - frame_count increments once per completed frame, in the cycle that frame completes.
  - flush clears both buffers.
- Not defined: single buffer exactly as specified in Behaviour; no shadow registers are synthesised.

Test Plan:
- Reset, then offer 10, 20, 30, 40 back-to-back with in_valid=1 -> one cycle after the 4th accept: frame_valid=1, frame_o[3]=10, frame_o[2]=20, frame_o[1]=30, frame_o[0]=40, frame_count=1, in_ready=0.
- With a frame held, keep in_valid=1 with in_data=99 for 5 cycles, then pulse frame_ack -> frame_o unchanged during the hold; next cycle frame_valid=0, in_ready=1, fill_level=0; the next accepted word is 99.
- Accept 2 words (1, 2), assert flush while offering 3 -> fill_level=0, frame_valid=0, frame_count unchanged; the subsequent words 5, 6, 7, 8 yield frame_o[3..0]=5, 6, 7, 8.
- Complete and ack 256 frames -> frame_count reads 0 after the 256th completion; assert reset mid-fill -> all outputs return to reset values asynchronously.
- With FRAME_PACKER_DBUF_EN: hold frame A (1, 2, 3, 4); stream B (5, 6, 7, 8), ack in the cycle B's last word is accepted -> frame_valid stays 1 and next cycle frame_o[3..0]=5, 6, 7, 8; frame_count=2.
- With FRAME_PACKER_DBUF_EN: both buffers full -> in_ready=0; ack -> in_ready=1 the next cycle.
